// File: rtl/dwishbone_bus_if.sv
// Wishbone master bridge between the CPU memory stage and the system bus.
// It accepts one CPU access at a time and runs one classic Wishbone cycle
// for it. The cycle ends on the slave ack, on a flush, or after TIMEOUT
// cycles without an ack. Load data is kept in a read buffer so the CPU can
// pick it up while its pipeline is still held by another source.
module dwishbone_bus_if #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_data_i,
   input  logic [3:0]  cpu_sel_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic [31:0] cpu_data_o,
   output logic        stallreq_o,
   output logic        bus_err_o,
   input  logic [31:0] wishbone_data_i,
   input  logic        wishbone_ack_i,
   output logic [31:0] wishbone_addr_o,
   output logic [31:0] wishbone_data_o,
   output logic        wishbone_we_o,
   output logic [3:0]  wishbone_sel_o,
   output logic        wishbone_stb_o,
   output logic        wishbone_cyc_o
);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_BUSY       = 2'd1;
   localparam logic [1:0] S_WAIT_STALL = 2'd2;

   // Last counter value before the abort edge: the counter starts at 0 in
   // the first BUSY cycle, so TIMEOUT cycles end when it reads TIMEOUT-1.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic        cyc_q, cyc_d;
   logic        err_q, err_d;
   logic        timeout_hit;

   assign timeout_hit = (state_q == S_BUSY) && (cnt_q >= TIMEOUT_LAST);

   // Next-state logic: flush beats ack, ack beats timeout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rbuf_d  = rbuf_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      sel_d   = sel_q;
      cyc_d   = cyc_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpu_ce_i && !flush_i) begin
               addr_d  = cpu_addr_i;
               wdata_d = cpu_data_i;
               we_d    = cpu_we_i;
               sel_d   = cpu_sel_i;
               cyc_d   = 1'b1;
               cnt_d   = 8'd0;
               rbuf_d  = 32'd0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (flush_i || wishbone_ack_i || timeout_hit) begin
               addr_d  = 32'd0;
               wdata_d = 32'd0;
               we_d    = 1'b0;
               sel_d   = 4'd0;
               cyc_d   = 1'b0;
               state_d = S_IDLE;
            end
            if (flush_i) begin
               // pending access abandoned, buffer untouched
            end else if (wishbone_ack_i) begin
               if (!we_q) begin
                  rbuf_d = wishbone_data_i;
               end
               if (stall_i) begin
                  state_d = S_WAIT_STALL;
               end
            end else if (timeout_hit) begin
               err_d  = 1'b1;
               rbuf_d = 32'd0;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WAIT_STALL: begin
            if (!stall_i || flush_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            addr_d  = 32'd0;
            wdata_d = 32'd0;
            we_d    = 1'b0;
            sel_d   = 4'd0;
            cyc_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and bus registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         rbuf_q  <= 32'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         cyc_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rbuf_q  <= rbuf_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         cyc_q   <= cyc_d;
         err_q   <= err_d;
      end
   end

   // CPU-facing stall request and load data; both read as reset state while rst is high.
   always_comb begin
      stallreq_o = 1'b0;
      cpu_data_o = 32'd0;
      if (!rst) begin
         case (state_q)
            S_IDLE: begin
               stallreq_o = cpu_ce_i & ~flush_i;
               cpu_data_o = rbuf_q;
            end
            S_BUSY: begin
               stallreq_o = ~wishbone_ack_i & ~flush_i & ~timeout_hit;
               if (wishbone_ack_i && !we_q) begin
                  cpu_data_o = wishbone_data_i;
               end
            end
            S_WAIT_STALL: begin
               cpu_data_o = rbuf_q;
            end
            default: begin
               stallreq_o = 1'b0;
               cpu_data_o = 32'd0;
            end
         endcase
      end
   end

   assign wishbone_addr_o = addr_q;
   assign wishbone_data_o = wdata_q;
   assign wishbone_we_o   = we_q;
   assign wishbone_sel_o  = sel_q;
   assign wishbone_stb_o  = cyc_q;
   assign wishbone_cyc_o  = cyc_q;
   assign bus_err_o       = err_q;

endmodule

// File: tb/tb_dwishbone_bus_if.sv
// Directed bench for dwishbone_bus_if: a per-cycle vector table covering
// load, store, stall hold, back-to-back, flush and mid-cycle reset, plus a
// hand-written sequence for the bus timeout.
module tb_dwishbone_bus_if;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_ce_i, cpu_we_i;
   logic [31:0] cpu_addr_i, cpu_data_i;
   logic [3:0]  cpu_sel_i;
   logic        stall_i, flush_i;
   logic [31:0] cpu_data_o;
   logic        stallreq_o, bus_err_o;
   logic [31:0] wishbone_data_i;
   logic        wishbone_ack_i;
   logic [31:0] wishbone_addr_o, wishbone_data_o;
   logic        wishbone_we_o;
   logic [3:0]  wishbone_sel_o;
   logic        wishbone_stb_o, wishbone_cyc_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dwishbone_bus_if #(.TIMEOUT(255)) dut (
      .clk             (clk),
      .rst             (rst),
      .cpu_ce_i        (cpu_ce_i),
      .cpu_we_i        (cpu_we_i),
      .cpu_addr_i      (cpu_addr_i),
      .cpu_data_i      (cpu_data_i),
      .cpu_sel_i       (cpu_sel_i),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .cpu_data_o      (cpu_data_o),
      .stallreq_o      (stallreq_o),
      .bus_err_o       (bus_err_o),
      .wishbone_data_i (wishbone_data_i),
      .wishbone_ack_i  (wishbone_ack_i),
      .wishbone_addr_o (wishbone_addr_o),
      .wishbone_data_o (wishbone_data_o),
      .wishbone_we_o   (wishbone_we_o),
      .wishbone_sel_o  (wishbone_sel_o),
      .wishbone_stb_o  (wishbone_stb_o),
      .wishbone_cyc_o  (wishbone_cyc_o)
   );

   // One record per clock cycle: inputs driven in that cycle and the outputs
   // expected during that same cycle (before the closing rising edge).
   typedef struct packed {
      logic        rst;
      logic        ce;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
      logic        stall;
      logic        flush;
      logic        ack;
      logic [31:0] wbd;
      logic        e_cyc;
      logic        e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_sel;
      logic        e_stallreq;
      logic [31:0] e_cpu;
      logic        e_err;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs [NVEC];

   function automatic vec_t mk(
      input logic r, input logic ce, input logic we, input logic [31:0] addr,
      input logic [31:0] data, input logic [3:0] sel, input logic stall,
      input logic flush, input logic ack, input logic [31:0] wbd,
      input logic e_cyc, input logic e_we, input logic [31:0] e_addr,
      input logic [31:0] e_wdata, input logic [3:0] e_sel,
      input logic e_stallreq, input logic [31:0] e_cpu, input logic e_err);
      vec_t v;
      v.rst = r; v.ce = ce; v.we = we; v.addr = addr; v.data = data;
      v.sel = sel; v.stall = stall; v.flush = flush; v.ack = ack; v.wbd = wbd;
      v.e_cyc = e_cyc; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
      v.e_sel = e_sel; v.e_stallreq = e_stallreq; v.e_cpu = e_cpu;
      v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic drive_idle();
      rst = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0;
      cpu_data_i = '0; cpu_sel_i = '0; stall_i = 1'b0; flush_i = 1'b0;
      wishbone_ack_i = 1'b0; wishbone_data_i = '0;
   endtask

   int  busy;
   logic done;

   initial begin
      //          rst ce we addr          data          sel  st fl ak wbd            cyc we eaddr         ewdata        esel sr ecpu          err
      vecs[0]  = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0);
      // load, ack in second BUSY cycle
      vecs[1]  = mk(0, 1, 0, 32'h20000010, 32'h0,        4'hF, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1, 32'h0,        0);
      vecs[2]  = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0,        1, 0, 32'h20000010, 32'h0,        4'hF, 1, 32'h0,        0);
      vecs[3]  = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 32'h20000010, 32'h0,        4'hF, 0, 32'hDEADBEEF, 0);
      vecs[4]  = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'hDEADBEEF, 0);
      // store, zero-wait ack
      vecs[5]  = mk(0, 1, 1, 32'h00000040, 32'h12345678, 4'h3, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1, 32'hDEADBEEF, 0);
      vecs[6]  = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 1, 32'hFFFFFFFF, 1, 1, 32'h00000040, 32'h12345678, 4'h3, 0, 32'h0,        0);
      vecs[7]  = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0);
      // load acked while stalled; WAIT_STALL for 3 cycles, late ack ignored
      vecs[8]  = mk(0, 1, 0, 32'h00000100, 32'h0,        4'hF, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1, 32'h0,        0);
      vecs[9]  = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 1, 32'hA5A5A5A5, 1, 0, 32'h00000100, 32'h0,        4'hF, 0, 32'hA5A5A5A5, 0);
      vecs[10] = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 1, 32'h11111111, 0, 0, 32'h0,        32'h0,        4'h0, 0, 32'hA5A5A5A5, 0);
      vecs[11] = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'hA5A5A5A5, 0);
      vecs[12] = mk(0, 1, 0, 32'h00000200, 32'h0,        4'hC, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'hA5A5A5A5, 0);
      // back-to-back loads
      vecs[13] = mk(0, 1, 0, 32'h00000200, 32'h0,        4'hC, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1, 32'hA5A5A5A5, 0);
      vecs[14] = mk(0, 1, 0, 32'h00000300, 32'h0,        4'hF, 0, 0, 1, 32'hCAFEF00D, 1, 0, 32'h00000200, 32'h0,        4'hC, 0, 32'hCAFEF00D, 0);
      vecs[15] = mk(0, 1, 0, 32'h00000300, 32'h0,        4'hF, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1, 32'hCAFEF00D, 0);
      // flush coincident with ack wins; flush in IDLE blocks accept
      vecs[16] = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 1, 1, 32'h77777777, 1, 0, 32'h00000300, 32'h0,        4'hF, 0, 32'h77777777, 0);
      vecs[17] = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0);
      vecs[18] = mk(0, 1, 0, 32'h00000600, 32'h0,        4'hF, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0);
      vecs[19] = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0);
      // reset in second BUSY cycle, then a stray ack
      vecs[20] = mk(0, 1, 1, 32'h00000400, 32'h55AA55AA, 4'hF, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 1, 32'h0,        0);
      vecs[21] = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0,        1, 1, 32'h00000400, 32'h55AA55AA, 4'hF, 1, 32'h0,        0);
      vecs[22] = mk(1, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0,        1, 1, 32'h00000400, 32'h55AA55AA, 4'hF, 0, 32'h0,        0);
      vecs[23] = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 1, 32'h99999999, 0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0);
      vecs[24] = mk(0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0);

      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         rst = vecs[i].rst; cpu_ce_i = vecs[i].ce; cpu_we_i = vecs[i].we;
         cpu_addr_i = vecs[i].addr; cpu_data_i = vecs[i].data;
         cpu_sel_i = vecs[i].sel; stall_i = vecs[i].stall;
         flush_i = vecs[i].flush; wishbone_ack_i = vecs[i].ack;
         wishbone_data_i = vecs[i].wbd;
         #1;
         chk("cyc",      i, 32'(wishbone_cyc_o),  32'(vecs[i].e_cyc));
         chk("stb",      i, 32'(wishbone_stb_o),  32'(vecs[i].e_cyc));
         chk("we",       i, 32'(wishbone_we_o),   32'(vecs[i].e_we));
         chk("addr",     i, wishbone_addr_o,      vecs[i].e_addr);
         chk("wdata",    i, wishbone_data_o,      vecs[i].e_wdata);
         chk("sel",      i, 32'(wishbone_sel_o),  32'(vecs[i].e_sel));
         chk("stallreq", i, 32'(stallreq_o),      32'(vecs[i].e_stallreq));
         chk("cpu_data", i, cpu_data_o,           vecs[i].e_cpu);
         chk("bus_err",  i, 32'(bus_err_o),       32'(vecs[i].e_err));
         $display("vec %0d: cyc=%0b addr=%08h stallreq=%0b cpu_data=%08h err=%0b",
                  i, wishbone_cyc_o, wishbone_addr_o, stallreq_o, cpu_data_o, bus_err_o);
      end

      // Timeout: load never acked; expect 255 BUSY cycles then a one-cycle error.
      @(negedge clk);
      drive_idle();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h00000500; cpu_sel_i = 4'hF;
      wishbone_data_i = 32'h12345678;
      #1;
      chk("to_accept_stallreq", 100, 32'(stallreq_o), 32'd1);
      @(negedge clk);
      cpu_ce_i = 1'b0;
      #1;
      busy = 0;
      done = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (wishbone_cyc_o) begin
            busy++;
            chk("to_busy_stallreq", 100 + busy, 32'(stallreq_o), (busy < 255) ? 32'd1 : 32'd0);
            chk("to_busy_err", 100 + busy, 32'(bus_err_o), 32'd0);
            @(negedge clk);
            #1;
         end else begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL to_bound actual=cyc_still_high required=cyc_low_within_300");
      end else begin
         chk("to_busy_cycles", 400, busy, 32'd255);
         chk("to_err_pulse",   401, 32'(bus_err_o), 32'd1);
         chk("to_cpu_data",    402, cpu_data_o, 32'd0);
         chk("to_stallreq",    403, 32'(stallreq_o), 32'd0);
         @(negedge clk);
         #1;
         chk("to_err_clear",   404, 32'(bus_err_o), 32'd0);
         chk("to_cyc_low",     405, 32'(wishbone_cyc_o), 32'd0);
      end
      $display("timeout: busy_cycles=%0d", busy);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
